keypad_auth_ctrl: RTL and testbench

Parametrised keypad login controller for the elevator's user-management path. It handles NUM_USERS users, each with a stored PIN, a fail counter and a lock flag; user 0 is the administrator. Users log in with `* ID # PIN #`. An admin session can rewrite any user's PIN and unlock that user. It also adds keypress edge detection, idle timeout and configurable ID/PIN lengths.

---
 rtl/auth_pkg.sv | 28 ++
 rtl/key_event_detect.sv | 35 +++
 rtl/keypad_auth_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_keypad_auth_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/auth_pkg.sv
// Shared definitions for the keypad login controller: key codes, FSM states and a
// width helper.
package auth_pkg;

  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;
  localparam logic [3:0] KEY_NONE = 4'hF;

  typedef enum logic [2:0] {
    StIdle,
    StIdEnt,
    StPinEnt,
    StCheck,
    StAdmIdle,
    StAdmId,
    StAdmPin,
    StAdmWrite
  } auth_state_e;

  // Index width for n entries, never below 1 bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/key_event_detect.sv
// Registers the raw keypad code and emits a one-cycle event on each press, so a
// held key yields exactly one event.
module key_event_detect
  import auth_pkg::*;
(
  input  logic       clk,
  input  logic       RST,
  input  logic [3:0] keypad,
  output logic       key_evt,
  output logic [3:0] key_val
);

  logic [3:0] key_s_q;
  logic [3:0] key_prev_q;
  logic       key_evt_q;
  logic [3:0] key_val_q;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      key_s_q    <= KEY_NONE;
      key_prev_q <= KEY_NONE;
      key_evt_q  <= 1'b0;
      key_val_q  <= KEY_NONE;
    end else begin
      key_s_q    <= keypad;
      key_prev_q <= key_s_q;
      key_evt_q  <= (key_s_q != KEY_NONE) && (key_prev_q == KEY_NONE);
      key_val_q  <= key_s_q;
    end
  end

  assign key_evt = key_evt_q;
  assign key_val = key_val_q;

endmodule

// File: rtl/keypad_auth_ctrl.sv
// Keypad login controller: per-user PIN, fail counter and lock, with an admin
// session (user 0) that can rewrite a PIN and unlock a user.
module keypad_auth_ctrl
  import auth_pkg::*;
#(
  parameter int unsigned                 NUM_USERS   = 8,
  parameter int unsigned                 ID_DIGITS   = 1,
  parameter int unsigned                 PIN_DIGITS  = 4,
  parameter int unsigned                 MAX_TRIES   = 3,
  parameter int unsigned                 TIMEOUT_CYC = 1000,
  parameter logic [PIN_DIGITS*4-1:0]     RESET_PIN   = 16'h1234
) (
  input  logic                          clk,
  input  logic                          RST,
  input  logic [3:0]                    keypad,
  output logic                          access_grant,
  output logic [clog2(NUM_USERS)-1:0]   grant_user,
  output logic                          access_deny,
  output logic                          user_locked,
  output logic                          admin_active,
  output logic                          pin_updated,
  output logic                          timeout
);

  localparam int unsigned UW   = clog2(NUM_USERS);
  localparam int unsigned PinW = PIN_DIGITS * 4;
  localparam int unsigned IdxW = 7;

  logic       key_evt;
  logic [3:0] key_val;

  key_event_detect u_key_event_detect (
    .clk    (clk),
    .RST    (RST),
    .keypad (keypad),
    .key_evt(key_evt),
    .key_val(key_val)
  );

  auth_state_e         state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [3:0]          dig_cnt_q, dig_cnt_d;
  logic [PinW-1:0]     pin_buf_q, pin_buf_d;
  logic [31:0]         tmo_cnt_q;
  logic [PinW-1:0]     pin_q [NUM_USERS];
  logic [3:0]          fail_q [NUM_USERS];
  logic [NUM_USERS-1:0] lock_q;

  logic          grant_d, deny_d, locked_d, upd_d, tmo_d, admin_d;
  logic [UW-1:0] grant_user_d;
  logic          pin_we, fail_we, lock_we, lock_wdata;
  logic [3:0]    fail_wdata, fail_inc;
  logic [UW-1:0] uidx;
  logic          is_digit, id_done, pin_done, id_bad, tmo_hit, is_adm;

  assign uidx     = idx_q[UW-1:0];
  assign is_digit = key_val <= 4'd9;
  assign id_done  = dig_cnt_q == 4'(ID_DIGITS);
  assign pin_done = dig_cnt_q == 4'(PIN_DIGITS);
  assign id_bad   = {25'd0, idx_q} >= NUM_USERS;
  assign tmo_hit  = (state_q != StIdle) && (tmo_cnt_q >= TIMEOUT_CYC - 1);
  assign fail_inc = (fail_q[uidx] == 4'hF) ? 4'hF : fail_q[uidx] + 4'd1;
  assign is_adm   = state_q inside {StAdmIdle, StAdmId, StAdmPin, StAdmWrite};

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    dig_cnt_d    = dig_cnt_q;
    pin_buf_d    = pin_buf_q;
    grant_d      = 1'b0;
    deny_d       = 1'b0;
    locked_d     = 1'b0;
    upd_d        = 1'b0;
    tmo_d        = 1'b0;
    grant_user_d = grant_user;
    pin_we       = 1'b0;
    fail_we      = 1'b0;
    fail_wdata   = 4'd0;
    lock_we      = 1'b0;
    lock_wdata   = 1'b0;

    if (tmo_hit) begin
      tmo_d     = 1'b1;
      state_d   = StIdle;
      idx_d     = '0;
      dig_cnt_d = '0;
      pin_buf_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (key_evt && key_val == KEY_STAR) begin
            state_d   = StIdEnt;
            idx_d     = '0;
            dig_cnt_d = '0;
            pin_buf_d = '0;
          end
        end
        StIdEnt, StAdmId: begin
          if (key_evt) begin
            if (key_val == KEY_STAR) begin
              idx_d     = '0;
              dig_cnt_d = '0;
            end else if (key_val == KEY_HASH) begin
              if (!id_done || id_bad) begin
                deny_d  = 1'b1;
                state_d = is_adm ? StAdmIdle : StIdle;
              end else if (!is_adm && lock_q[uidx]) begin
                deny_d   = 1'b1;
                locked_d = 1'b1;
                state_d  = StIdle;
              end else begin
                state_d   = is_adm ? StAdmPin : StPinEnt;
                dig_cnt_d = '0;
                pin_buf_d = '0;
              end
            end else if (is_digit) begin
              if (id_done) begin
                deny_d  = 1'b1;
                state_d = is_adm ? StAdmIdle : StIdle;
              end else begin
                idx_d     = IdxW'(idx_q * 7'd10) + {3'd0, key_val};
                dig_cnt_d = dig_cnt_q + 4'd1;
              end
            end
          end
        end
        StPinEnt, StAdmPin: begin
          if (key_evt) begin
            if (key_val == KEY_STAR) begin
              state_d   = is_adm ? StAdmId : StIdEnt;
              idx_d     = '0;
              dig_cnt_d = '0;
              pin_buf_d = '0;
            end else if (key_val == KEY_HASH) begin
              if (pin_done) begin
                state_d = is_adm ? StAdmWrite : StCheck;
              end else begin
                deny_d  = 1'b1;
                state_d = is_adm ? StAdmIdle : StIdle;
              end
            end else if (is_digit) begin
              if (pin_done) begin
                deny_d  = 1'b1;
                state_d = is_adm ? StAdmIdle : StIdle;
              end else begin
                pin_buf_d = (pin_buf_q << 4) | PinW'(key_val);
                dig_cnt_d = dig_cnt_q + 4'd1;
              end
            end
          end
        end
        StCheck: begin
          fail_we = 1'b1;
          if (pin_q[uidx] == pin_buf_q) begin
            grant_d      = 1'b1;
            grant_user_d = uidx;
            fail_wdata   = 4'd0;
            state_d      = (idx_q == '0) ? StAdmIdle : StIdle;
          end else begin
            deny_d     = 1'b1;
            fail_wdata = fail_inc;
            // The admin entry never locks, otherwise the system could become unmanageable.
            if (fail_inc >= 4'(MAX_TRIES) && idx_q != '0) begin
              lock_we    = 1'b1;
              lock_wdata = 1'b1;
              locked_d   = 1'b1;
            end
            state_d = StIdle;
          end
        end
        StAdmIdle: begin
          if (key_evt && key_val == KEY_STAR) begin
            state_d   = StAdmId;
            idx_d     = '0;
            dig_cnt_d = '0;
          end else if (key_evt && key_val == KEY_HASH) begin
            state_d = StIdle;
          end
        end
        StAdmWrite: begin
          pin_we     = 1'b1;
          fail_we    = 1'b1;
          fail_wdata = 4'd0;
          lock_we    = 1'b1;
          lock_wdata = 1'b0;
          upd_d      = 1'b1;
          state_d    = StAdmIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    admin_d = state_d inside {StAdmIdle, StAdmId, StAdmPin, StAdmWrite};
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      dig_cnt_q    <= '0;
      pin_buf_q    <= '0;
      tmo_cnt_q    <= '0;
      access_grant <= 1'b0;
      grant_user   <= '0;
      access_deny  <= 1'b0;
      user_locked  <= 1'b0;
      admin_active <= 1'b0;
      pin_updated  <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      dig_cnt_q    <= dig_cnt_d;
      pin_buf_q    <= pin_buf_d;
      tmo_cnt_q    <= (state_q == StIdle || key_evt || tmo_hit) ? 32'd0 : tmo_cnt_q + 32'd1;
      access_grant <= grant_d;
      grant_user   <= grant_user_d;
      access_deny  <= deny_d;
      user_locked  <= locked_d;
      admin_active <= admin_d;
      pin_updated  <= upd_d;
      timeout      <= tmo_d;
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NUM_USERS; i++) begin
        pin_q[i]  <= RESET_PIN;
        fail_q[i] <= 4'd0;
      end
      lock_q <= '0;
    end else begin
      if (pin_we) pin_q[uidx] <= pin_buf_q;
      if (fail_we) fail_q[uidx] <= fail_wdata;
      if (lock_we) lock_q[uidx] <= lock_wdata;
    end
  end

endmodule

// File: tb/tb_keypad_auth_ctrl.sv
// Directed bench for keypad_auth_ctrl: login, lockout, admin PIN rewrite, format
// errors, key hold, idle timeout and reset.
module tb_keypad_auth_ctrl;

  localparam int unsigned TMO = 1000;
  localparam logic [3:0] STAR = 4'hA;
  localparam logic [3:0] HASH = 4'hB;
  localparam logic [3:0] NONE = 4'hF;

  logic       clk;
  logic       RST;
  logic [3:0] keypad;
  logic       access_grant;
  logic [2:0] grant_user;
  logic       access_deny;
  logic       user_locked;
  logic       admin_active;
  logic       pin_updated;
  logic       timeout;

  keypad_auth_ctrl #(
    .NUM_USERS  (8),
    .ID_DIGITS  (1),
    .PIN_DIGITS (4),
    .MAX_TRIES  (3),
    .TIMEOUT_CYC(TMO),
    .RESET_PIN  (16'h1234)
  ) dut (
    .clk         (clk),
    .RST         (RST),
    .keypad      (keypad),
    .access_grant(access_grant),
    .grant_user  (grant_user),
    .access_deny (access_deny),
    .user_locked (user_locked),
    .admin_active(admin_active),
    .pin_updated (pin_updated),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Cumulative pulse counters, sampled on the falling edge.
  int n_grant = 0, n_deny = 0, n_locked = 0, n_upd = 0, n_tmo = 0;
  int b_grant, b_deny, b_locked, b_upd, b_tmo;
  int last_user = 0;

  always @(negedge clk) begin
    if (access_grant) begin
      n_grant   = n_grant + 1;
      last_user = int'(grant_user);
    end
    if (access_deny) n_deny = n_deny + 1;
    if (user_locked) n_locked = n_locked + 1;
    if (pin_updated) n_upd = n_upd + 1;
    if (timeout) n_tmo = n_tmo + 1;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic mark();
    b_grant  = n_grant;
    b_deny   = n_deny;
    b_locked = n_locked;
    b_upd    = n_upd;
    b_tmo    = n_tmo;
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk) keypad = k;
    repeat (2) @(negedge clk);
    keypad = NONE;
    repeat (2) @(negedge clk);
  endtask

  task automatic login(input logic [3:0] id, input logic [15:0] pin);
    press(STAR);
    press(id);
    press(HASH);
    for (int i = 3; i >= 0; i--) press(pin[i*4 +: 4]);
    press(HASH);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_grant"}, int'(access_grant), 0);
    check_eq({tag, "_deny"}, int'(access_deny), 0);
    check_eq({tag, "_locked"}, int'(user_locked), 0);
    check_eq({tag, "_admin"}, int'(admin_active), 0);
    check_eq({tag, "_upd"}, int'(pin_updated), 0);
    check_eq({tag, "_tmo"}, int'(timeout), 0);
    check_eq({tag, "_user"}, int'(grant_user), 0);
  endtask

  initial begin
    RST    = 1'b0;
    keypad = NONE;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    RST = 1'b1;
    repeat (2) @(negedge clk);

    // User 3 login with exact pulse latency after the final '#'.
    mark();
    press(STAR); press(4'd3); press(HASH);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    @(negedge clk) keypad = HASH;
    repeat (3) @(negedge clk);
    check_eq("lat_t2_grant", int'(access_grant), 0);
    keypad = NONE;
    @(negedge clk);
    check_eq("lat_t3_grant", int'(access_grant), 1);
    check_eq("lat_t3_user", int'(grant_user), 3);
    check_eq("lat_t3_admin", int'(admin_active), 0);
    repeat (3) @(negedge clk);
    check_eq("u3_grant_once", n_grant - b_grant, 1);

    // User 5 locks out after three wrong PINs.
    for (int k = 1; k <= 3; k++) begin
      mark();
      login(4'd5, 16'h9999);
      check_eq("u5_wrong_deny", n_deny - b_deny, 1);
      check_eq("u5_wrong_locked", n_locked - b_locked, (k == 3) ? 1 : 0);
    end
    mark();
    login(4'd5, 16'h1234);
    check_eq("u5_locked_deny", n_deny - b_deny, 1);
    check_eq("u5_locked_flag", n_locked - b_locked, 1);
    check_eq("u5_locked_nogrant", n_grant - b_grant, 0);

    // Admin rewrites user 5 PIN, which also unlocks it.
    mark();
    login(4'd0, 16'h1234);
    check_eq("adm_grant", n_grant - b_grant, 1);
    check_eq("adm_user", last_user, 0);
    check_eq("adm_active", int'(admin_active), 1);
    mark();
    login(4'd5, 16'h4321);
    check_eq("adm_upd", n_upd - b_upd, 1);
    check_eq("adm_upd_nogrant", n_grant - b_grant, 0);
    check_eq("adm_still_active", int'(admin_active), 1);
    press(HASH);
    check_eq("adm_logout", int'(admin_active), 0);
    mark();
    login(4'd5, 16'h4321);
    check_eq("u5_new_grant", n_grant - b_grant, 1);
    check_eq("u5_new_user", last_user, 5);

    // Format errors leave user 3's fail count untouched.
    mark();
    press(STAR); press(HASH);
    repeat (4) @(negedge clk);
    check_eq("fmt_early_id", n_deny - b_deny, 1);
    mark();
    press(STAR); press(4'd3); press(HASH);
    press(4'd1); press(4'd2); press(4'd3); press(HASH);
    repeat (4) @(negedge clk);
    check_eq("fmt_short_pin", n_deny - b_deny, 1);
    mark();
    press(STAR); press(4'd1); press(4'd2);
    repeat (4) @(negedge clk);
    check_eq("fmt_long_id", n_deny - b_deny, 1);
    for (int k = 1; k <= 3; k++) begin
      mark();
      login(4'd3, 16'h0000);
      check_eq("u3_wrong_locked", n_locked - b_locked, (k == 3) ? 1 : 0);
    end
    mark();
    login(4'd9, 16'h1234);
    check_eq("id9_deny", n_deny - b_deny, 1);
    check_eq("id9_nogrant", n_grant - b_grant, 0);

    // A held key counts once.
    mark();
    press(STAR); press(4'd1); press(HASH);
    @(negedge clk) keypad = 4'd1;
    repeat (20) @(negedge clk);
    keypad = NONE;
    repeat (2) @(negedge clk);
    press(4'd2); press(4'd3); press(4'd4); press(HASH);
    repeat (4) @(negedge clk);
    check_eq("hold_grant", n_grant - b_grant, 1);
    check_eq("hold_user", last_user, 1);
    check_eq("hold_nodeny", n_deny - b_deny, 0);

    // Idle timeout in PIN entry returns to IDLE.
    mark();
    press(STAR); press(4'd1); press(HASH);
    repeat (TMO - 20) @(negedge clk);
    check_eq("tmo_early", n_tmo - b_tmo, 0);
    repeat (40) @(negedge clk);
    check_eq("tmo_fired", n_tmo - b_tmo, 1);
    check_eq("tmo_nodeny", n_deny - b_deny, 0);
    mark();
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(HASH);
    repeat (4) @(negedge clk);
    check_eq("tmo_idle_nogrant", n_grant - b_grant, 0);
    check_eq("tmo_idle_nodeny", n_deny - b_deny, 0);

    // Idle timeout closes an admin session.
    login(4'd0, 16'h1234);
    check_eq("tmo_adm_open", int'(admin_active), 1);
    mark();
    repeat (TMO + 20) @(negedge clk);
    check_eq("tmo_adm_closed", int'(admin_active), 0);
    check_eq("tmo_adm_pulse", n_tmo - b_tmo, 1);

    // Reset mid-PIN restores PINs and clears locks.
    press(STAR); press(4'd5); press(HASH); press(4'd4); press(4'd3);
    @(negedge clk) RST = 1'b0;
    @(negedge clk);
    check_outputs_zero("midrst");
    RST = 1'b1;
    repeat (2) @(negedge clk);
    mark();
    login(4'd5, 16'h1234);
    check_eq("rst_u5_grant", n_grant - b_grant, 1);
    check_eq("rst_u5_user", last_user, 5);
    mark();
    login(4'd3, 16'h1234);
    check_eq("rst_u3_unlock", n_grant - b_grant, 1);
    check_eq("rst_u3_user", last_user, 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
